// File: rtl/clock_calendar_gen2_pkg.sv
// clock_calendar_gen2_pkg: shared constants, field encodings and wrap helper for clock_calendar_gen2
package clock_calendar_gen2_pkg;
  localparam int CAL_SOLAR = 0;
  localparam int CAL_GREG = 1;
  typedef enum logic [2:0] {
    F_SEC  = 3'd0,
    F_MIN  = 3'd1,
    F_HR   = 3'd2,
    F_DAY  = 3'd3,
    F_MON  = 3'd4,
    F_YR   = 3'd5,
    F_WDAY = 3'd6,
    F_NONE = 3'd7
  } field_e;
  localparam logic [4:0] LEN_28 = 5'd28;
  localparam logic [4:0] LEN_29 = 5'd29;
  localparam logic [4:0] LEN_30 = 5'd30;
  localparam logic [4:0] LEN_31 = 5'd31;
  // one setup step within [lo, hi], wrapping at both ends
  function automatic logic [15:0] wrap_step(input logic [15:0] v, input logic [15:0] lo,
                                            input logic [15:0] hi, input logic up);
    return up ? ((v >= hi) ? lo : v + 16'd1) : ((v <= lo) ? hi : v - 16'd1);
  endfunction
endpackage

// File: rtl/clock_calendar_gen2_month_len_lut.sv
// month_len_lut: combinational month length for the selected calendar
//   month_i   : month 1..12
//   year_lo_i : two low bits of the year (leap detection)
//   len_o     : number of days in that month
module month_len_lut
  import clock_calendar_gen2_pkg::*;
#(
  parameter int CAL_MODE = CAL_SOLAR
) (
  input  logic [3:0] month_i,
  input  logic [1:0] year_lo_i,
  output logic [4:0] len_o
);
  logic [4:0] greg_len, solar_len;
  assign greg_len = (month_i == 4'd2) ? ((year_lo_i == 2'd0) ? LEN_29 : LEN_28) :
                    (month_i == 4'd4 || month_i == 4'd6 || month_i == 4'd9 || month_i == 4'd11) ? LEN_30 : LEN_31;
  // Solar Hijri leap year when year % 4 == 3
  assign solar_len = (month_i <= 4'd6) ? LEN_31 : (month_i <= 4'd11) ? LEN_30 :
                     (year_lo_i == 2'd3) ? LEN_30 : LEN_29;
  assign len_o = (CAL_MODE == CAL_GREG) ? greg_len : solar_len;
endmodule

// File: rtl/clock_calendar_gen2.sv
// clock_calendar_gen2: time/date/weekday keeper with tick prescaler, setup editing and rollover strobes
//   clk, rst_n            : clock, asynchronous active-low reset
//   tick_in               : tick pulses, TICK_DIV per second (run mode only)
//   set_mode              : 1 = setup (edit fields), 0 = run
//   field_sel, inc, dec   : field to edit and single-cycle step requests (inc wins)
//   seconds..weekday      : registered calendar state
//   sec_strobe, day_strobe: one-cycle pulses on second event / midnight rollover
//   CLOCK_CALENDAR_ALARM_EN: adds alarm_hr, alarm_min, alarm_arm, alarm_clr, alarm_flag
module clock_calendar_gen2
  import clock_calendar_gen2_pkg::*;
#(
  parameter int CAL_MODE = CAL_SOLAR,
  parameter int TICK_DIV = 1,
  parameter int YEAR_W   = 7,
  parameter int YEAR_MAX = 99,
  parameter int RST_YEAR = 4,
  parameter int RST_WDAY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick_in,
  input  logic              set_mode,
  input  logic [2:0]        field_sel,
  input  logic              inc,
  input  logic              dec,
`ifdef CLOCK_CALENDAR_ALARM_EN
  input  logic [4:0]        alarm_hr,
  input  logic [5:0]        alarm_min,
  input  logic              alarm_arm,
  input  logic              alarm_clr,
  output logic              alarm_flag,
`endif
  output logic [5:0]        seconds,
  output logic [5:0]        minutes,
  output logic [4:0]        hours,
  output logic [4:0]        day,
  output logic [3:0]        month,
  output logic [YEAR_W-1:0] year,
  output logic [2:0]        weekday,
  output logic              sec_strobe,
  output logic              day_strobe
);
  logic [5:0] sec_q, sec_d, min_q, min_d;
  logic [4:0] hr_q, hr_d, day_q, day_d, day_e;
  logic [3:0] mon_q, mon_d, mon_e;
  logic [YEAR_W-1:0] yr_q, yr_d, yr_e;
  logic [2:0] wday_q, wday_d;
  logic [15:0] pre_q, pre_d;
  logic sstb_q, dstb_q;
  logic [4:0] len_cur, len_new;
  logic [6:0] sel;
  logic ev, c_m, c_h, c_d, c_mo, c_y;

  month_len_lut #(.CAL_MODE(CAL_MODE)) u_len_cur (
    .month_i(mon_q), .year_lo_i(yr_q[1:0]), .len_o(len_cur)
  );
  // length after a pending month/year edit, used to clamp day in the same edge
  month_len_lut #(.CAL_MODE(CAL_MODE)) u_len_new (
    .month_i(mon_e), .year_lo_i(yr_e[1:0]), .len_o(len_new)
  );

  // one-hot edit select; field 7 falls off the top and is a no-op
  assign sel = (set_mode && (inc || dec)) ? 7'(8'd1 << field_sel) : 7'd0;

  assign ev   = !set_mode && tick_in && (pre_q == 16'(TICK_DIV - 1));
  assign c_m  = ev && (sec_q == 6'd59);
  assign c_h  = c_m && (min_q == 6'd59);
  assign c_d  = c_h && (hr_q == 5'd23);
  assign c_mo = c_d && (day_q >= len_cur);
  assign c_y  = c_mo && (mon_q == 4'd12);

  assign mon_e = sel[F_MON] ? 4'(wrap_step(16'(mon_q), 16'd1, 16'd12, inc)) : mon_q;
  assign yr_e  = sel[F_YR] ? YEAR_W'(wrap_step(16'(yr_q), 16'd0, 16'(YEAR_MAX), inc)) : yr_q;
  assign day_e = sel[F_DAY] ? 5'(wrap_step(16'(day_q), 16'd1, 16'(len_cur), inc)) : day_q;

  assign pre_d  = (set_mode || ev) ? 16'd0 : pre_q + 16'(tick_in);
  assign sec_d  = sel[F_SEC] ? 6'(wrap_step(16'(sec_q), 16'd0, 16'd59, inc)) :
                  !ev ? sec_q : c_m ? 6'd0 : sec_q + 6'd1;
  assign min_d  = sel[F_MIN] ? 6'(wrap_step(16'(min_q), 16'd0, 16'd59, inc)) :
                  !c_m ? min_q : c_h ? 6'd0 : min_q + 6'd1;
  assign hr_d   = sel[F_HR] ? 5'(wrap_step(16'(hr_q), 16'd0, 16'd23, inc)) :
                  !c_h ? hr_q : c_d ? 5'd0 : hr_q + 5'd1;
  assign day_d  = set_mode ? ((day_e > len_new) ? len_new : day_e) :
                  !c_d ? day_q : c_mo ? 5'd1 : day_q + 5'd1;
  assign mon_d  = set_mode ? mon_e : !c_mo ? mon_q : c_y ? 4'd1 : mon_q + 4'd1;
  assign yr_d   = set_mode ? yr_e : !c_y ? yr_q :
                  (yr_q == YEAR_W'(YEAR_MAX)) ? '0 : yr_q + YEAR_W'(1);
  assign wday_d = sel[F_WDAY] ? 3'(wrap_step(16'(wday_q), 16'd0, 16'd6, inc)) :
                  !c_d ? wday_q : (wday_q == 3'd6) ? 3'd0 : wday_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_q  <= '0;
      min_q  <= '0;
      hr_q   <= '0;
      day_q  <= 5'd1;
      mon_q  <= 4'd1;
      yr_q   <= YEAR_W'(RST_YEAR);
      wday_q <= 3'(RST_WDAY);
      pre_q  <= '0;
      sstb_q <= 1'b0;
      dstb_q <= 1'b0;
    end else begin
      sec_q  <= sec_d;
      min_q  <= min_d;
      hr_q   <= hr_d;
      day_q  <= day_d;
      mon_q  <= mon_d;
      yr_q   <= yr_d;
      wday_q <= wday_d;
      pre_q  <= pre_d;
      sstb_q <= ev;
      dstb_q <= c_d;
    end
  end

`ifdef CLOCK_CALENDAR_ALARM_EN
  logic alarm_q, alarm_d;
  // set has priority over clear
  assign alarm_d = (ev && alarm_arm && hr_d == alarm_hr && min_d == alarm_min && sec_d == 6'd0) ||
                   (alarm_q && !alarm_clr);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) alarm_q <= 1'b0;
    else alarm_q <= alarm_d;
  end
  assign alarm_flag = alarm_q;
`endif

  assign seconds    = sec_q;
  assign minutes    = min_q;
  assign hours      = hr_q;
  assign day        = day_q;
  assign month      = mon_q;
  assign year       = yr_q;
  assign weekday    = wday_q;
  assign sec_strobe = sstb_q;
  assign day_strobe = dstb_q;
endmodule

// File: tb/tb_clock_calendar_gen2.sv
// tb_clock_calendar_gen2: directed scoreboard bench for a Solar (TICK_DIV=4) and a Gregorian (TICK_DIV=1) instance
module tb_clock_calendar_gen2;
  import clock_calendar_gen2_pkg::*;
  logic clk, rst_n, tick_in, set_mode, inc, dec;
  logic [2:0] field_sel;
  logic [5:0] s_sec, s_min, g_sec, g_min;
  logic [4:0] s_hr, s_day, g_hr, g_day;
  logic [3:0] s_mon, g_mon;
  logic [6:0] s_yr, g_yr;
  logic [2:0] s_wd, g_wd;
  logic s_ss, s_ds, g_ss, g_ds;
`ifdef CLOCK_CALENDAR_ALARM_EN
  logic [4:0] alarm_hr;
  logic [5:0] alarm_min;
  logic alarm_arm, alarm_clr, s_alarm, g_alarm;
`endif
  typedef struct {
    string tag;
    logic [37:0] v;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  clock_calendar_gen2 #(.CAL_MODE(CAL_SOLAR), .TICK_DIV(4), .RST_WDAY(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_mode(set_mode), .field_sel(field_sel),
    .inc(inc), .dec(dec),
`ifdef CLOCK_CALENDAR_ALARM_EN
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_arm(alarm_arm), .alarm_clr(alarm_clr),
    .alarm_flag(s_alarm),
`endif
    .seconds(s_sec), .minutes(s_min), .hours(s_hr), .day(s_day), .month(s_mon), .year(s_yr),
    .weekday(s_wd), .sec_strobe(s_ss), .day_strobe(s_ds)
  );

  clock_calendar_gen2 #(.CAL_MODE(CAL_GREG), .TICK_DIV(1)) dut_g (
    .clk(clk), .rst_n(rst_n), .tick_in(tick_in), .set_mode(set_mode), .field_sel(field_sel),
    .inc(inc), .dec(dec),
`ifdef CLOCK_CALENDAR_ALARM_EN
    .alarm_hr(alarm_hr), .alarm_min(alarm_min), .alarm_arm(alarm_arm), .alarm_clr(alarm_clr),
    .alarm_flag(g_alarm),
`endif
    .seconds(g_sec), .minutes(g_min), .hours(g_hr), .day(g_day), .month(g_mon), .year(g_yr),
    .weekday(g_wd), .sec_strobe(g_ss), .day_strobe(g_ds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [37:0] mk(input int s, input int mi, input int h, input int d, input int mo,
                                     input int y, input int w, input int ss, input int ds);
    return {6'(s), 6'(mi), 5'(h), 5'(d), 4'(mo), 7'(y), 3'(w), 1'(ss), 1'(ds)};
  endfunction
  function automatic logic [37:0] snap_s();
    return {s_sec, s_min, s_hr, s_day, s_mon, s_yr, s_wd, s_ss, s_ds};
  endfunction
  function automatic logic [37:0] snap_g();
    return {g_sec, g_min, g_hr, g_day, g_mon, g_yr, g_wd, g_ss, g_ds};
  endfunction

  task automatic expect_st(input string t, input logic [37:0] v);
    q.push_back('{t, v});
  endtask
  task automatic check_st(input logic [37:0] obs);
    exp_t x;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with no expectation queued", obs);
      return;
    end
    x = q.pop_front();
    assert (obs === x.v) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", x.tag, obs, x.v);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    tick_in = 1'b0;
    set_mode = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    field_sel = 3'd7;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask
  task automatic edit(input logic [2:0] f, input logic up, input int n);
    set_mode = 1'b1;
    field_sel = f;
    inc = up;
    dec = !up;
    cyc(n);
    inc = 1'b0;
    dec = 1'b0;
    field_sel = 3'd7;
  endtask
  task automatic to_2359();
    edit(F_HR, 1'b0, 1);
    edit(F_MIN, 1'b0, 1);
    edit(F_SEC, 1'b0, 1);
  endtask
  task automatic run_ticks(input int n);
    set_mode = 1'b0;
    tick_in = 1'b1;
    cyc(n);
    tick_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    tick_in = 1'b0;
    set_mode = 1'b0;
    inc = 1'b0;
    dec = 1'b0;
    field_sel = 3'd7;
`ifdef CLOCK_CALENDAR_ALARM_EN
    alarm_hr = '0;
    alarm_min = '0;
    alarm_arm = 1'b0;
    alarm_clr = 1'b0;
`endif
    cyc(2);
    expect_st("reset_s", mk(0, 0, 0, 1, 1, 4, 2, 0, 0));
    check_st(snap_s());
    expect_st("reset_g", mk(0, 0, 0, 1, 1, 4, 0, 0, 0));
    check_st(snap_g());
    rst_n = 1'b1;
    cyc();

    for (int i = 1; i <= 8; i++) begin
      tick_in = 1'b1;
      expect_st("presc_tick", mk(i / 4, 0, 0, 1, 1, 4, 2, (i % 4 == 0) ? 1 : 0, 0));
      cyc();
      check_st(snap_s());
      tick_in = 1'b0;
      expect_st("presc_idle", mk(i / 4, 0, 0, 1, 1, 4, 2, 0, 0));
      cyc();
      check_st(snap_s());
    end
    expect_st("div1_count", mk(8, 0, 0, 1, 1, 4, 0, 0, 0));
    check_st(snap_g());

    set_mode = 1'b1;
    tick_in = 1'b1;
    expect_st("setup_tick_dropped", mk(8, 0, 0, 1, 1, 4, 0, 0, 0));
    cyc();
    tick_in = 1'b0;
    check_st(snap_g());

    do_reset();
    edit(F_MON, 1'b1, 1);
    edit(F_YR, 1'b1, 20);
    edit(F_DAY, 1'b0, 2);
    to_2359();
    expect_st("greg_leap_setup", mk(59, 59, 23, 28, 2, 24, 0, 0, 0));
    check_st(snap_g());
    expect_st("greg_feb29", mk(0, 0, 0, 29, 2, 24, 1, 1, 1));
    run_ticks(1);
    check_st(snap_g());

    do_reset();
    edit(F_MON, 1'b1, 1);
    edit(F_YR, 1'b1, 21);
    edit(F_DAY, 1'b0, 1);
    to_2359();
    expect_st("greg_nonleap_setup", mk(59, 59, 23, 28, 2, 25, 0, 0, 0));
    check_st(snap_g());
    expect_st("greg_mar1", mk(0, 0, 0, 1, 3, 25, 1, 1, 1));
    run_ticks(1);
    check_st(snap_g());

    do_reset();
    edit(F_YR, 1'b0, 1);
    edit(F_MON, 1'b0, 1);
    edit(F_DAY, 1'b0, 1);
    to_2359();
    expect_st("solar_leap_setup", mk(59, 59, 23, 30, 12, 3, 2, 0, 0));
    check_st(snap_s());
    expect_st("solar_presc_hold", mk(59, 59, 23, 30, 12, 3, 2, 0, 0));
    run_ticks(3);
    check_st(snap_s());
    expect_st("solar_newyear_leap", mk(0, 0, 0, 1, 1, 4, 3, 1, 1));
    run_ticks(1);
    check_st(snap_s());

    do_reset();
    edit(F_MON, 1'b0, 1);
    edit(F_DAY, 1'b0, 1);
    to_2359();
    expect_st("solar_29_setup", mk(59, 59, 23, 29, 12, 4, 2, 0, 0));
    check_st(snap_s());
    expect_st("solar_newyear_29", mk(0, 0, 0, 1, 1, 5, 3, 1, 1));
    run_ticks(4);
    check_st(snap_s());

    do_reset();
    edit(F_MON, 1'b1, 5);
    edit(F_DAY, 1'b0, 1);
    expect_st("setup_day31", mk(0, 0, 0, 31, 6, 4, 2, 0, 0));
    check_st(snap_s());
    edit(F_MON, 1'b1, 1);
    expect_st("month_clamp", mk(0, 0, 0, 30, 7, 4, 2, 0, 0));
    check_st(snap_s());
    edit(F_MIN, 1'b1, 5);
    set_mode = 1'b1;
    field_sel = F_MIN;
    inc = 1'b1;
    dec = 1'b1;
    cyc();
    inc = 1'b0;
    dec = 1'b0;
    expect_st("inc_wins", mk(0, 6, 0, 30, 7, 4, 2, 0, 0));
    check_st(snap_s());
    edit(F_WDAY, 1'b0, 3);
    expect_st("wday_dec_wrap", mk(0, 6, 0, 30, 7, 4, 6, 0, 0));
    check_st(snap_s());
    field_sel = 3'd7;
    inc = 1'b1;
    cyc();
    inc = 1'b0;
    expect_st("field7_noop", mk(0, 6, 0, 30, 7, 4, 6, 0, 0));
    check_st(snap_s());

    do_reset();
    edit(F_YR, 1'b0, 1);
    edit(F_MON, 1'b0, 1);
    edit(F_DAY, 1'b0, 1);
    edit(F_YR, 1'b1, 1);
    expect_st("year_clamp", mk(0, 0, 0, 29, 12, 4, 2, 0, 0));
    check_st(snap_s());
    edit(F_DAY, 1'b1, 1);
    expect_st("day_inc_wrap", mk(0, 0, 0, 1, 12, 4, 2, 0, 0));
    check_st(snap_s());

    do_reset();
    edit(F_YR, 1'b0, 5);
    edit(F_MON, 1'b0, 1);
    edit(F_DAY, 1'b0, 1);
    to_2359();
    expect_st("yearmax_setup", mk(59, 59, 23, 30, 12, 99, 2, 0, 0));
    check_st(snap_s());
    expect_st("yearmax_wrap", mk(0, 0, 0, 1, 1, 0, 3, 1, 1));
    run_ticks(4);
    check_st(snap_s());
    rst_n = 1'b0;
    #2;
    expect_st("async_reset_s", mk(0, 0, 0, 1, 1, 4, 2, 0, 0));
    check_st(snap_s());
    expect_st("async_reset_g", mk(0, 0, 0, 1, 1, 4, 0, 0, 0));
    check_st(snap_g());
    rst_n = 1'b1;
    cyc();

`ifdef CLOCK_CALENDAR_ALARM_EN
    do_reset();
    edit(F_HR, 1'b1, 7);
    edit(F_MIN, 1'b1, 29);
    edit(F_SEC, 1'b0, 1);
    alarm_hr = 5'd7;
    alarm_min = 6'd30;
    alarm_arm = 1'b1;
    expect_st("alarm_idle", 38'd0);
    check_st(38'(g_alarm));
    expect_st("alarm_set", 38'd1);
    run_ticks(1);
    check_st(38'(g_alarm));
    set_mode = 1'b1;
    cyc(3);
    expect_st("alarm_sticky", 38'd1);
    check_st(38'(g_alarm));
    alarm_clr = 1'b1;
    cyc();
    alarm_clr = 1'b0;
    expect_st("alarm_clr", 38'd0);
    check_st(38'(g_alarm));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
